mcu_addr_engine: RTL and testbench
==================================

Name: mcu_addr_engine

Overview:
- Parametrised successor to the MCU command interpreter's address/stream path.
- Holds NUM_CH independent address pointers of ADDR_W bits, each with a wrap mask.
- The MCU loads, streams and reads back these pointers over the SPI command/parameter byte interface; SD DMA advances any selected channel.
- Sits between the SPI slave and the memory arbiter, replacing the fixed ROM/DAC/MSU pointer trio.

Parameters:
- NUM_CH, 4, number of address channels (1..16); CH_W = max(1, clog2(NUM_CH)) is a localparam.
- ADDR_W, 24, pointer width in bits (8..32); ADDR_BYTES = ceil(ADDR_W/8) is a localparam.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- cmd_ready  in  1  one-cycle pulse: cmd_data holds a new command byte.
- param_ready  in  1  one-cycle pulse: param_data holds the next parameter byte.
- cmd_data  in  8  current command byte.
- param_data  in  8  current parameter byte.
- mcu_rrq  out  1  one-cycle memory read request.
- mcu_wrq  out  1  one-cycle memory write request.
- mcu_rq_rdy  in  1  arbiter ready level; its rising edge completes a request.
- mcu_data_in  in  8  read data from memory.
- mcu_data_out  out  8  write data to memory.
- spi_data_out  out  8  byte returned to the MCU on the next SPI transfer.
- dma_nextaddr  in  1  SD DMA advance pulse.
- dma_ch  out  CH_W  channel selected for DMA advance.
- active_ch  out  CH_W  channel of the current or last stream command.
- active_addr  out  ADDR_W  pointer of active_ch.
- addr_flat  out  NUM_CH*ADDR_W  all pointers; channel i occupies [i*ADDR_W +: ADDR_W].

Behaviour:
- Reset: all pointers 0; all masks all-ones; mcu_rrq=0; mcu_wrq=0; mcu_data_out=0; spi_data_out=0; dma_ch=0; active_ch=0; state IDLE; byte index 0; rq_rdy_d=0.
- Command decode on cmd_ready, from any state; this aborts any command in progress.
  - Channel c = cmd_data[3:0].
  - c >= NUM_CH, or an unknown opcode: go to IDLE, no side effects, spi_data_out=0xFF.
  - Byte index k is cleared on cmd_ready and incremented on each param_ready.
- Opcodes (cmd_data[7:4]) and target states:
  - 0x0 -> LOAD_ADDR
  - 0x1 -> LOAD_MASK
  - 0x4 -> set dma_ch=c, then IDLE
  - 0x8 -> RD_STREAM
  - 0x9 -> WR_STREAM
  - 0xA -> READBACK
- LOAD_ADDR / LOAD_MASK:
  - Parameter byte k (0-based, MSB first) writes bits [8*(ADDR_BYTES-1-k) +: 8] of the target register; bits >= ADDR_W are discarded.
  - In LOAD_ADDR, k=0 also clears all lower bits.
  - Bytes with k >= ADDR_BYTES are ignored.
- Increment rule for channel c:
  - addr <= (addr & ~mask) | ((addr+1) & mask).
  - With the all-ones mask this is a plain modulo-2^ADDR_W increment.
  - A mask of 0x0003FF wraps within a 1 KiB window.
- Request-complete detect:
  - rq_rdy_d is mcu_rq_rdy registered.
  - nextaddr = mcu_rq_rdy & ~rq_rdy_d.
  - The pointer update is visible on the cycle after nextaddr.
- RD_STREAM:
  - cmd_ready and every param_ready produce mcu_rrq=1 on the following cycle, for exactly one cycle.
  - On nextaddr: spi_data_out <= mcu_data_in and pointer c increments.
- WR_STREAM:
  - cmd_ready only selects the channel.
  - Each param_ready: mcu_data_out <= param_data and mcu_wrq=1 on the following cycle, for exactly one cycle.
  - On nextaddr: pointer c increments.
- READBACK:
  - At cmd_ready, pointer c is snapshotted and spi_data_out <= snapshot MSB byte.
  - Each param_ready presents the next byte.
  - After ADDR_BYTES bytes, spi_data_out = 0x00.
  - Later increments do not alter the snapshot.
- DMA: dma_nextaddr increments pointer dma_ch in any state.
- Simultaneous events:
  - A load byte on channel c takes priority over any increment of c in the same cycle.
  - Stream and DMA increments on the same channel in the same cycle give a single +1.
  - Increments on different channels in the same cycle both apply.
  - nextaddr outside RD_STREAM/WR_STREAM is ignored.
- rst mid-stream: all state returns to reset values next cycle; pending requests are dropped.

Decomposition:
- Package mcu_addr_pkg holds:
  - opcode constants: OP_LDADDR=4'h0, OP_LDMASK=4'h1, OP_DMASEL=4'h4, OP_RD=4'h8, OP_WR=4'h9, OP_RDBK=4'hA;
  - the state enum {IDLE, LOAD_ADDR, LOAD_MASK, RD_STREAM, WR_STREAM, READBACK};
  - the ERR_BYTE=8'hFF constant.
- One sub-module, mcu_addr_chan: a single pointer+mask register with byte-load and masked increment; instantiated NUM_CH times via generate.

Test Plan:
- Load: cmd 0x02, params 12 34 56 -> channel 2 = 0x123456; others 0. Partial load (cmd 0x02, param 0x7F only) -> 0x7F0000.
- Masked wrap: set ch1 addr 0x0003FE, mask 0x0003FF; cmd 0x81 plus two rq_rdy rising edges -> 0x0003FF, then 0x000000; each rrq is one cycle long.
- Read stream: ch0=0x000010; cmd 0x80; rq_rdy edge with mcu_data_in=0xA5 -> spi_data_out=0xA5, ch0=0x000011. A held-high rq_rdy gives only one increment.
- Write stream: cmd 0x93, params 0x11 0x22 -> mcu_data_out 0x11 then 0x22, two wrq pulses; ch3 increments only on rq_rdy edges.
- Collision: ch0 in RD_STREAM, dma_ch=0; nextaddr and dma_nextaddr in the same cycle -> +1 only. Same cycle with dma_ch=1 -> both ch0 and ch1 +1.
- Readback/abort: ch2=0xABCDEF; cmd 0xA2 -> AB, CD, EF, 00. New cmd_ready mid-load -> old load abandoned. rst mid-RD_STREAM -> all pointers 0, no rrq. cmd 0x0F with NUM_CH=4 -> spi_data_out=0xFF.

Source files
------------

// File: rtl/mcu_addr_pkg.sv
// mcu_addr_pkg: opcodes, error byte and command-state encoding for mcu_addr_engine.
`default_nettype none

package mcu_addr_pkg;

  localparam logic [3:0] OP_LDADDR = 4'h0;
  localparam logic [3:0] OP_LDMASK = 4'h1;
  localparam logic [3:0] OP_DMASEL = 4'h4;
  localparam logic [3:0] OP_RD     = 4'h8;
  localparam logic [3:0] OP_WR     = 4'h9;
  localparam logic [3:0] OP_RDBK   = 4'hA;

  localparam logic [7:0] ERR_BYTE  = 8'hFF;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_ADDR = 3'd1,
    LOAD_MASK = 3'd2,
    RD_STREAM = 3'd3,
    WR_STREAM = 3'd4,
    READBACK  = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mcu_addr_chan.sv
// mcu_addr_chan: one address pointer with wrap mask, MSB-first byte load and masked increment.
`default_nettype none

module mcu_addr_chan #(
  parameter int ADDR_W     = 24,
  parameter int ADDR_BYTES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_addr,
  input  logic              load_mask,
  input  logic [2:0]        byte_idx,
  input  logic [7:0]        load_byte,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr
);

  localparam int WB = ADDR_BYTES * 8;

  logic [ADDR_W-1:0] mask;
  logic [5:0]        shamt;
  logic [WB-1:0]     byte_pos;
  logic [WB-1:0]     byte_mask;
  logic [ADDR_W-1:0] addr_loaded;
  logic [ADDR_W-1:0] mask_loaded;
  logic [ADDR_W-1:0] addr_inc;

  always_comb begin
    shamt       = (int'(byte_idx) < ADDR_BYTES) ? 6'(8 * (ADDR_BYTES - 1 - int'(byte_idx))) : 6'd0;
    byte_pos    = WB'(load_byte) << shamt;
    byte_mask   = WB'(8'hFF) << shamt;
    // The first byte of an address load also clears everything below it.
    addr_loaded = (byte_idx == 3'd0) ? ADDR_W'(byte_pos)
                                     : ADDR_W'((WB'(addr) & ~byte_mask) | byte_pos);
    mask_loaded = ADDR_W'((WB'(mask) & ~byte_mask) | byte_pos);
    addr_inc    = (addr & ~mask) | ((addr + ADDR_W'(1)) & mask);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
      mask <= '1;
    end else begin
      if (load_addr)
        addr <= addr_loaded;
      else if (inc)
        addr <= addr_inc;
      if (load_mask)
        mask <= mask_loaded;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mcu_addr_engine.sv
// mcu_addr_engine: NUM_CH masked address pointers driven by SPI command/parameter bytes,
// memory request completion and SD DMA advance pulses.
`default_nettype none

module mcu_addr_engine
  import mcu_addr_pkg::*;
#(
  parameter  int NUM_CH     = 4,
  parameter  int ADDR_W     = 24,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int ADDR_BYTES = (ADDR_W + 7) / 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_ready,
  input  logic                     param_ready,
  input  logic [7:0]               cmd_data,
  input  logic [7:0]               param_data,
  output logic                     mcu_rrq,
  output logic                     mcu_wrq,
  input  logic                     mcu_rq_rdy,
  input  logic [7:0]               mcu_data_in,
  output logic [7:0]               mcu_data_out,
  output logic [7:0]               spi_data_out,
  input  logic                     dma_nextaddr,
  output logic [CH_W-1:0]          dma_ch,
  output logic [CH_W-1:0]          active_ch,
  output logic [ADDR_W-1:0]        active_addr,
  output logic [NUM_CH*ADDR_W-1:0] addr_flat
);

  localparam int WB = ADDR_BYTES * 8;

  state_t            state, state_next;
  logic [CH_W-1:0]   tgt_ch;
  logic [2:0]        k;
  logic              rq_rdy_d;
  logic [WB-1:0]     snap;
  logic [ADDR_W-1:0] addr_arr [NUM_CH];

  logic [3:0]        cmd_op;
  logic [CH_W-1:0]   cmd_ch;
  logic              cmd_valid;
  logic              nextaddr;
  logic              stream_inc;
  logic              load_ok;
  logic [WB-1:0]     rb_ext;

  assign cmd_op     = cmd_data[7:4];
  assign cmd_ch     = cmd_data[CH_W-1:0];
  assign cmd_valid  = (int'(cmd_data[3:0]) < NUM_CH) &&
                      (cmd_op == OP_LDADDR || cmd_op == OP_LDMASK || cmd_op == OP_DMASEL ||
                       cmd_op == OP_RD || cmd_op == OP_WR || cmd_op == OP_RDBK);
  assign nextaddr   = mcu_rq_rdy & ~rq_rdy_d;
  assign stream_inc = nextaddr & ~cmd_ready & (state == RD_STREAM || state == WR_STREAM);
  assign load_ok    = param_ready & ~cmd_ready & (int'(k) < ADDR_BYTES);
  assign rb_ext     = WB'(addr_arr[cmd_ch]);
  assign active_addr = addr_arr[active_ch];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (cmd_ready) begin
      state_next = IDLE;
      if (cmd_valid) begin
        case (cmd_op)
          OP_LDADDR: state_next = LOAD_ADDR;
          OP_LDMASK: state_next = LOAD_MASK;
          OP_RD:     state_next = RD_STREAM;
          OP_WR:     state_next = WR_STREAM;
          OP_RDBK:   state_next = READBACK;
          default:   state_next = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rq_rdy_d     <= 1'b0;
      mcu_rrq      <= 1'b0;
      mcu_wrq      <= 1'b0;
      mcu_data_out <= 8'h00;
      spi_data_out <= 8'h00;
      dma_ch       <= '0;
      active_ch    <= '0;
      tgt_ch       <= '0;
      k            <= 3'd0;
      snap         <= '0;
    end else begin
      rq_rdy_d <= mcu_rq_rdy;
      mcu_rrq  <= 1'b0;
      mcu_wrq  <= 1'b0;
      if (cmd_ready) begin
        k <= 3'd0;
        if (!cmd_valid) begin
          spi_data_out <= ERR_BYTE;
        end else begin
          tgt_ch <= cmd_ch;
          case (cmd_op)
            OP_DMASEL: dma_ch <= cmd_ch;
            OP_RD: begin
              active_ch <= cmd_ch;
              mcu_rrq   <= 1'b1;
            end
            OP_WR:     active_ch <= cmd_ch;
            // Readback shifts a private copy so later increments never leak in;
            // once every byte has been shifted out the copy is all zeros.
            OP_RDBK: begin
              spi_data_out <= rb_ext[WB-1 -: 8];
              snap         <= rb_ext << 8;
            end
            default: ;
          endcase
        end
      end else begin
        if (param_ready) begin
          if (int'(k) < ADDR_BYTES) k <= k + 3'd1;
          case (state)
            RD_STREAM: mcu_rrq <= 1'b1;
            WR_STREAM: begin
              mcu_data_out <= param_data;
              mcu_wrq      <= 1'b1;
            end
            READBACK: begin
              spi_data_out <= snap[WB-1 -: 8];
              snap         <= snap << 8;
            end
            default: ;
          endcase
        end
        if (nextaddr && state == RD_STREAM)
          spi_data_out <= mcu_data_in;
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    logic ld_addr, ld_mask, inc;
    assign ld_addr = load_ok && state == LOAD_ADDR && tgt_ch == CH_W'(i);
    assign ld_mask = load_ok && state == LOAD_MASK && tgt_ch == CH_W'(i);
    assign inc     = (stream_inc && active_ch == CH_W'(i)) ||
                     (dma_nextaddr && dma_ch == CH_W'(i));

    mcu_addr_chan #(
      .ADDR_W     (ADDR_W),
      .ADDR_BYTES (ADDR_BYTES)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .load_addr (ld_addr),
      .load_mask (ld_mask),
      .byte_idx  (k),
      .load_byte (param_data),
      .inc       (inc),
      .addr      (addr_arr[i])
    );

    assign addr_flat[i*ADDR_W +: ADDR_W] = addr_arr[i];
  end

endmodule

`default_nettype wire

// File: tb/tb_mcu_addr_engine.sv
// tb_mcu_addr_engine: directed and random byte-level stimulus against a transaction-level model.
`default_nettype none

module tb_mcu_addr_engine;

  localparam int ST_IDLE = 0, ST_LA = 1, ST_LM = 2, ST_RD = 3, ST_WR = 4, ST_RB = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_ready = 1'b0, param_ready = 1'b0;
  logic [7:0]  cmd_data = 8'h00, param_data = 8'h00;
  logic        mcu_rrq, mcu_wrq;
  logic        mcu_rq_rdy = 1'b0;
  logic [7:0]  mcu_data_in = 8'h00;
  logic [7:0]  mcu_data_out, spi_data_out;
  logic        dma_nextaddr = 1'b0;
  logic [1:0]  dma_ch, active_ch;
  logic [23:0] active_addr;
  logic [95:0] addr_flat;

  mcu_addr_engine #(.NUM_CH(4), .ADDR_W(24)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_ready    (cmd_ready),
    .param_ready  (param_ready),
    .cmd_data     (cmd_data),
    .param_data   (param_data),
    .mcu_rrq      (mcu_rrq),
    .mcu_wrq      (mcu_wrq),
    .mcu_rq_rdy   (mcu_rq_rdy),
    .mcu_data_in  (mcu_data_in),
    .mcu_data_out (mcu_data_out),
    .spi_data_out (spi_data_out),
    .dma_nextaddr (dma_nextaddr),
    .dma_ch       (dma_ch),
    .active_ch    (active_ch),
    .active_addr  (active_addr),
    .addr_flat    (addr_flat)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: pointers, masks and the MCU-visible registers.
  logic [23:0] m_addr [4];
  logic [23:0] m_mask [4];
  int          m_st, m_k;
  logic [1:0]  m_ch, m_act, m_dma;
  logic [7:0]  m_spi, m_dout;
  logic [7:0]  m_rb [$];
  logic        exp_rrq, exp_wrq;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_addr[i] = 24'h0;
      m_mask[i] = 24'hFFFFFF;
    end
    m_st = ST_IDLE; m_k = 0; m_ch = 0; m_act = 0; m_dma = 0;
    m_spi = 8'h00; m_dout = 8'h00; m_rb.delete();
  endtask

  function automatic logic [23:0] bumped(input logic [23:0] a, input logic [23:0] m);
    return (a & ~m) | ((a + 24'd1) & m);
  endfunction

  task automatic check_all(input string tag);
    check_eq({tag, ".addr"}, addr_flat, {m_addr[3], m_addr[2], m_addr[1], m_addr[0]});
    check_eq({tag, ".spi"},  spi_data_out, m_spi);
    check_eq({tag, ".dma"},  dma_ch, m_dma);
    check_eq({tag, ".act"},  active_ch, m_act);
    check_eq({tag, ".aadr"}, active_addr, m_addr[m_act]);
    check_eq({tag, ".dout"}, mcu_data_out, m_dout);
  endtask

  task automatic model_cmd(input logic [7:0] b);
    int op, c;
    op = int'(b[7:4]); c = int'(b[3:0]);
    m_k = 0; exp_rrq = 1'b0; exp_wrq = 1'b0;
    if (c >= 4 || !(op inside {0, 1, 4, 8, 9, 10})) begin
      m_st = ST_IDLE; m_spi = 8'hFF;
    end else begin
      case (op)
        0:  begin m_st = ST_LA; m_ch = 2'(c); end
        1:  begin m_st = ST_LM; m_ch = 2'(c); end
        4:  begin m_st = ST_IDLE; m_dma = 2'(c); end
        8:  begin m_st = ST_RD; m_act = 2'(c); exp_rrq = 1'b1; end
        9:  begin m_st = ST_WR; m_act = 2'(c); end
        default: begin
          m_st  = ST_RB;
          m_spi = m_addr[c][23:16];
          m_rb  = {m_addr[c][15:8], m_addr[c][7:0]};
        end
      endcase
    end
  endtask

  task automatic model_param(input logic [7:0] b);
    exp_rrq = 1'b0; exp_wrq = 1'b0;
    case (m_st)
      ST_LA: if (m_k < 3) begin
        if (m_k == 0) m_addr[m_ch] = {b, 16'h0000};
        else          m_addr[m_ch][8*(2-m_k) +: 8] = b;
      end
      ST_LM: if (m_k < 3) m_mask[m_ch][8*(2-m_k) +: 8] = b;
      ST_RD: exp_rrq = 1'b1;
      ST_WR: begin m_dout = b; exp_wrq = 1'b1; end
      ST_RB: m_spi = (m_rb.size() > 0) ? m_rb.pop_front() : 8'h00;
      default: ;
    endcase
    m_k++;
  endtask

  task automatic do_cmd(input logic [7:0] b);
    @(negedge clk); cmd_data = b; cmd_ready = 1'b1;
    model_cmd(b);
    @(negedge clk); cmd_ready = 1'b0;
    check_eq("cmd.rrq", mcu_rrq, exp_rrq);
    check_eq("cmd.wrq", mcu_wrq, 1'b0);
    @(negedge clk);
    check_eq("cmd.rq_len", {mcu_rrq, mcu_wrq}, 2'b00);
    check_all("cmd");
  endtask

  task automatic do_param(input logic [7:0] b);
    @(negedge clk); param_data = b; param_ready = 1'b1;
    model_param(b);
    @(negedge clk); param_ready = 1'b0;
    check_eq("par.rrq", mcu_rrq, exp_rrq);
    check_eq("par.wrq", mcu_wrq, exp_wrq);
    @(negedge clk);
    check_eq("par.rq_len", {mcu_rrq, mcu_wrq}, 2'b00);
    check_all("par");
  endtask

  // Rising edge of mcu_rq_rdy and/or a DMA pulse in the same cycle; rq_rdy may stay high.
  task automatic do_event(input bit rq, input bit dma, input logic [7:0] din, input int hold);
    bit [3:0] hit;
    @(negedge clk);
    mcu_rq_rdy = rq; mcu_data_in = din; dma_nextaddr = dma;
    hit = '0;
    if (rq && (m_st == ST_RD || m_st == ST_WR)) hit[m_act] = 1'b1;
    if (rq && m_st == ST_RD) m_spi = din;
    if (dma) hit[m_dma] = 1'b1;
    for (int i = 0; i < 4; i++)
      if (hit[i]) m_addr[i] = bumped(m_addr[i], m_mask[i]);
    @(negedge clk); dma_nextaddr = 1'b0;
    check_eq("evt.rq", {mcu_rrq, mcu_wrq}, 2'b00);
    check_all("evt");
    repeat (hold) @(negedge clk);
    mcu_rq_rdy = 1'b0;
    if (hold > 0) check_all("evt.hold");
  endtask

  task automatic load3(input logic [7:0] cmd, input logic [23:0] v);
    do_cmd(cmd); do_param(v[23:16]); do_param(v[15:8]); do_param(v[7:0]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("reset.rq", {mcu_rrq, mcu_wrq}, 2'b00);
    check_all("reset");

    // Loads, partial load, abandoned load
    load3(8'h02, 24'h123456);
    check_eq("load.ch2", addr_flat[71:48], 24'h123456);
    do_cmd(8'h02); do_param(8'h7F);
    check_eq("partial.ch2", addr_flat[71:48], 24'h7F0000);
    do_cmd(8'h01); do_param(8'hAA); do_cmd(8'h80); do_param(8'hBB);
    check_eq("abort.ch1", addr_flat[47:24], 24'hAA0000);

    // Masked wrap in a 1 KiB window
    load3(8'h01, 24'h0003FE);
    load3(8'h11, 24'h0003FF);
    do_cmd(8'h81);
    do_event(1'b1, 1'b0, 8'h00, 0);
    check_eq("wrap.1", addr_flat[47:24], 24'h0003FF);
    do_event(1'b1, 1'b0, 8'h00, 0);
    check_eq("wrap.2", addr_flat[47:24], 24'h000000);

    // Read stream, held-high rq_rdy
    load3(8'h00, 24'h000010);
    do_cmd(8'h80);
    do_event(1'b1, 1'b0, 8'hA5, 3);
    check_eq("rd.spi", spi_data_out, 8'hA5);
    check_eq("rd.ch0", addr_flat[23:0], 24'h000011);

    // Write stream
    do_cmd(8'h93);
    do_param(8'h11);
    check_eq("wr.d1", mcu_data_out, 8'h11);
    do_param(8'h22);
    check_eq("wr.d2", mcu_data_out, 8'h22);
    do_event(1'b1, 1'b0, 8'h00, 1);

    // Collisions
    do_cmd(8'h40); do_cmd(8'h80);
    do_event(1'b1, 1'b1, 8'h3C, 0);
    do_cmd(8'h41); do_cmd(8'h80);
    do_event(1'b1, 1'b1, 8'h3D, 0);

    // Readback
    load3(8'h02, 24'hABCDEF);
    do_cmd(8'hA2);
    check_eq("rb.0", spi_data_out, 8'hAB);
    do_event(1'b0, 1'b1, 8'h00, 0);
    do_param(8'h00); check_eq("rb.1", spi_data_out, 8'hCD);
    do_param(8'h00); check_eq("rb.2", spi_data_out, 8'hEF);
    do_param(8'h00); check_eq("rb.3", spi_data_out, 8'h00);

    // Invalid channel / opcode
    do_cmd(8'h0F); check_eq("bad.ch", spi_data_out, 8'hFF);
    do_cmd(8'h32); check_eq("bad.op", spi_data_out, 8'hFF);

    // Reset in the middle of a read stream drops the pending request
    do_cmd(8'h80);
    @(negedge clk); param_ready = 1'b1; rst = 1'b1;
    @(negedge clk); param_ready = 1'b0; rst = 1'b0;
    model_reset();
    check_eq("rst.rrq", mcu_rrq, 1'b0);
    check_all("rst");

    // Random traffic
    for (int it = 0; it < 400; it++) begin
      int r;
      logic [7:0] b;
      r = int'($urandom_range(0, 9));
      if (r <= 2) begin
        int ops [6] = '{0, 1, 4, 8, 9, 10};
        b = {4'(ops[$urandom_range(0, 5)]), 4'($urandom_range(0, 4))};
        do_cmd(b);
      end else if (r <= 5) begin
        do_param(8'($urandom));
      end else if (r <= 7) begin
        do_event(1'b1, 1'($urandom), 8'($urandom), int'($urandom_range(0, 2)));
      end else if (r == 8) begin
        do_event(1'b0, 1'b1, 8'h00, 0);
      end else begin
        do_cmd(8'($urandom));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
